// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio sample feeder: FSM state encoding
// and the sample-tick divisor derived from the clock and sampling rates.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_GAP
  } feeder_state_t;

  function automatic int unsigned TICK_DIVISOR(input int unsigned system_hz,
                                               input int unsigned sampling_hz);
    return system_hz / sampling_hz;
  endfunction

endpackage

// File: rtl/audio_sample_feeder_if.sv
// Producer-side sample stream and serializer handshake of the audio feeder,
// bundled for benches and integration wrappers.
interface audio_sample_feeder_if #(
  parameter int unsigned WORD_LENGTH = 16
) ();

  logic [WORD_LENGTH-1:0] sample;
  logic                   sample_valid;
  logic                   sample_ready;
  logic [WORD_LENGTH-1:0] ser_data;
  logic                   ser_enable;
  logic                   ser_done;
  logic                   underrun;
  logic                   late;

  modport master (
    output sample, sample_valid, ser_done,
    input  sample_ready, ser_data, ser_enable, underrun, late
  );

  modport slave (
    input  sample, sample_valid, ser_done,
    output sample_ready, ser_data, ser_enable, underrun, late
  );

endinterface

// File: rtl/sample_fifo.sv
// Power-of-two sample buffer; pointers wrap naturally, count is one bit wider
// so full and empty are distinguishable.
module sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/audio_sample_feeder.sv
// Buffers producer samples and hands one word per sample tick to a downstream
// serializer, flagging underruns and ticks that arrive faster than service.
module audio_sample_feeder
  import audio_pkg::*;
#(
  parameter int unsigned WORD_LENGTH        = 16,
  parameter int unsigned SYSTEM_FREQUENCY   = 100000000,
  parameter int unsigned SAMPLING_FREQUENCY = 1000000,
  parameter int unsigned FIFO_DEPTH         = 8
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [WORD_LENGTH-1:0] sample_i,
  input  logic                   sample_valid_i,
  output logic                   sample_ready_o,
  output logic [WORD_LENGTH-1:0] ser_data_o,
  output logic                   ser_enable_o,
  input  logic                   ser_done_i,
  output logic                   underrun_o,
  output logic                   late_o
);

  localparam int unsigned DIV = TICK_DIVISOR(SYSTEM_FREQUENCY, SAMPLING_FREQUENCY);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(FIFO_DEPTH);

  feeder_state_t          state_q, state_d;
  logic [CW-1:0]          tick_cnt_q, tick_cnt_d;
  logic                   pending_q, pending_d;
  logic                   late_q, late_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic                   tick;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [WORD_LENGTH-1:0] fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [PW:0]            fifo_count;

  assign sample_ready_o = (fifo_count < DEPTH_CNT);
  assign fifo_push      = sample_valid_i && !fifo_full;
  assign ser_data_o     = data_q;
  assign late_o         = late_q;

  sample_fifo #(
    .WIDTH (WORD_LENGTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .push_i  (fifo_push),
    .data_i  (sample_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    late_d       = late_q;
    data_d       = data_q;
    ser_enable_o = 1'b0;
    underrun_o   = 1'b0;
    fifo_pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tick || pending_q) begin
          state_d   = ST_LOAD;
          // a fresh tick landing while a pending one is consumed stays pending
          pending_d = tick && pending_q;
        end
      end
      ST_LOAD: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_head;
        end else begin
          underrun_o = 1'b1;
        end
        state_d = ST_RUN;
      end
      ST_RUN: begin
        ser_enable_o = 1'b1;
        if (ser_done_i) state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (tick) begin
      if (pending_q)               late_d    = 1'b1;
      else if (state_q != ST_IDLE) pending_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      pending_q  <= 1'b0;
      late_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      pending_q  <= pending_d;
      late_q     <= late_d;
      data_q     <= data_d;
    end
  end

endmodule
